// File: rtl/dcache_if.sv
// Core/memory-side bundle of the dcache: M-stage load/store request, load result,
// stall, and the req/ack handshake to the backing data memory.
interface dcache_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 17
);
    logic                     re;
    logic                     we;
    logic [2:0]               funct3;
    logic [DATA_WIDTH-1:0]    addr;
    logic [DATA_WIDTH-1:0]    wd;
    logic [DATA_WIDTH-1:0]    rd;
    logic                     stall;
    logic                     mem_req;
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [31:0]              mem_wdata;
    logic [3:0]               mem_wstrb;
    logic                     mem_ack;
    logic [31:0]              mem_rdata;

    modport slave (
        input  re, we, funct3, addr, wd, mem_ack, mem_rdata,
        output rd, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output re, we, funct3, addr, wd, mem_ack, mem_rdata,
        input  rd, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache (one word per line).
// Define DCACHE_STATS_EN to add the hit_count/miss_count load statistics ports.
module dcache #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 17,
    parameter int SETS          = 64
) (
    input  logic        clk,
    input  logic        rst,
    dcache_if.slave     bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDRESS_WIDTH - IDX_W - 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [SETS-1:0]          valid_q;
    logic [TAG_W-1:0]         tag_q  [SETS];
    logic [31:0]              data_q [SETS];
    logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                     mem_we_q, mem_we_d;
    logic [31:0]              mem_wdata_q, mem_wdata_d;
    logic [3:0]               mem_wstrb_q, mem_wstrb_d;

    logic [IDX_W-1:0] idx_s, ln_idx_s;
    logic [TAG_W-1:0] tag_s, ln_tag_s;
    logic             hit_s, ln_hit_s, fill_s, merge_s, stall_s;
    logic [31:0]      rd_s;
    logic             unused_addr_s;

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3[1:0])
            2'b00:   r = {{24{b[7] & ~f3[2]}}, b};
            2'b01:   r = {{16{h[15] & ~f3[2]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] s;
        case (f3[1:0])
            2'b00:   s = 4'b0001 << off;
            2'b01:   s = off[1] ? 4'b1100 : 4'b0011;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] store_data(input logic [31:0] wd, input logic [2:0] f3,
                                               input logic [1:0] off);
        logic [31:0] d;
        case (f3[1:0])
            2'b00:   d = {24'd0, wd[7:0]} << {off, 3'b000};
            2'b01:   d = off[1] ? {wd[15:0], 16'd0} : {16'd0, wd[15:0]};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return r;
    endfunction

    assign idx_s    = bus.addr[IDX_W+1:2];
    assign tag_s    = bus.addr[ADDRESS_WIDTH-1:IDX_W+2];
    assign hit_s    = valid_q[idx_s] && (tag_q[idx_s] == tag_s);
    // Line updates use the registered transaction address, not the live bus.
    assign ln_idx_s = mem_addr_q[IDX_W+1:2];
    assign ln_tag_s = mem_addr_q[ADDRESS_WIDTH-1:IDX_W+2];
    assign ln_hit_s = valid_q[ln_idx_s] && (tag_q[ln_idx_s] == ln_tag_s);
    assign fill_s   = (state_q == RD_MISS) && bus.mem_ack && !rst;
    assign merge_s  = (state_q == WR_THRU) && bus.mem_ack && ln_hit_s && !rst;

    assign unused_addr_s = ^bus.addr[DATA_WIDTH-1:ADDRESS_WIDTH];

    // Next-state, load result, stall and transaction capture.
    always_comb begin
        state_d     = state_q;
        rd_s        = 32'd0;
        stall_s     = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        case (state_q)
            IDLE: begin
                if (bus.we) begin
                    stall_s     = 1'b1;
                    state_d     = WR_THRU;
                    mem_addr_d  = {bus.addr[ADDRESS_WIDTH-1:2], 2'b00};
                    mem_we_d    = 1'b1;
                    mem_wdata_d = store_data(bus.wd, bus.funct3, bus.addr[1:0]);
                    mem_wstrb_d = store_strb(bus.funct3, bus.addr[1:0]);
                end else if (bus.re) begin
                    if (hit_s) begin
                        rd_s = load_extract(data_q[idx_s], bus.funct3, bus.addr[1:0]);
                    end else begin
                        stall_s     = 1'b1;
                        state_d     = RD_MISS;
                        mem_addr_d  = {bus.addr[ADDRESS_WIDTH-1:2], 2'b00};
                        mem_we_d    = 1'b0;
                        mem_wdata_d = 32'd0;
                        mem_wstrb_d = 4'b0000;
                    end
                end else begin
                    rd_s = 32'd0;
                end
            end
            RD_MISS: begin
                if (bus.mem_ack) begin
                    rd_s    = load_extract(bus.mem_rdata, bus.funct3, bus.addr[1:0]);
                    state_d = IDLE;
                end else begin
                    stall_s = 1'b1;
                end
            end
            WR_THRU: begin
                if (bus.mem_ack) begin
                    state_d = IDLE;
                end else begin
                    stall_s = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, valid bits and the registered memory-side request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 32'd0;
            mem_wstrb_q <= 4'b0000;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            if (fill_s) begin
                valid_q[ln_idx_s] <= 1'b1;
            end
        end
    end

    // Tag/data arrays need no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (fill_s) begin
            tag_q[ln_idx_s]  <= ln_tag_s;
            data_q[ln_idx_s] <= bus.mem_rdata;
        end else if (merge_s) begin
            data_q[ln_idx_s] <= merge_bytes(data_q[ln_idx_s], mem_wdata_q, mem_wstrb_q);
        end
    end

    assign bus.rd        = rst ? 32'd0 : rd_s;
    assign bus.stall     = rst ? 1'b0 : stall_s;
    assign bus.mem_req   = (state_q != IDLE);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count_q, miss_count_q;

    // Load statistics, sampled on the IDLE detect cycle only.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_q  <= 32'd0;
            miss_count_q <= 32'd0;
        end else if ((state_q == IDLE) && bus.re && !bus.we) begin
            if (hit_s) begin
                hit_count_q <= hit_count_q + 32'd1;
            end else begin
                miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif
endmodule

// File: tb/tb_dcache.sv
// Directed self-checking bench for dcache: hits, misses, extraction, stores,
// index conflicts, no-write-allocate and reset during a read miss.
module tb_dcache;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    dcache_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(17)) bus ();

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    dcache #(.DATA_WIDTH(32), .ADDRESS_WIDTH(17), .SETS(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input bit hit, input int lat, input logic [31:0] mdata,
                           input logic [31:0] exp);
        @(negedge clk);
        bus.re = 1'b1; bus.we = 1'b0; bus.funct3 = f3; bus.addr = a; bus.mem_ack = 1'b0;
        #1;
        if (hit) begin
            check({tag, "_stall"}, {31'd0, bus.stall}, 32'd0);
            check({tag, "_rd"}, bus.rd, exp);
            check({tag, "_req"}, {31'd0, bus.mem_req}, 32'd0);
        end else begin
            check({tag, "_stall"}, {31'd0, bus.stall}, 32'd1);
            for (int k = 1; k <= lat; k++) begin
                @(negedge clk);
                bus.mem_ack   = (k == lat);
                bus.mem_rdata = (k == lat) ? mdata : 32'h0BAD0BAD;
                #1;
                check({tag, "_req"}, {31'd0, bus.mem_req}, 32'd1);
                check({tag, "_maddr"}, {15'd0, bus.mem_addr}, a & 32'h0001FFFC);
                check({tag, "_mwe"}, {31'd0, bus.mem_we}, 32'd0);
                if (k < lat) begin
                    check({tag, "_stall_w"}, {31'd0, bus.stall}, 32'd1);
                end else begin
                    check({tag, "_stall_a"}, {31'd0, bus.stall}, 32'd0);
                    check({tag, "_rd"}, bus.rd, exp);
                end
            end
        end
        @(negedge clk);
        bus.re = 1'b0; bus.mem_ack = 1'b0;
        #1;
        check({tag, "_req_end"}, {31'd0, bus.mem_req}, 32'd0);
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input int lat,
                            input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
        @(negedge clk);
        bus.we = 1'b1; bus.re = 1'b0; bus.funct3 = f3; bus.addr = a; bus.wd = wd;
        bus.mem_ack = 1'b0;
        #1;
        check({tag, "_stall"}, {31'd0, bus.stall}, 32'd1);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            bus.mem_ack = (k == lat);
            #1;
            check({tag, "_req"}, {31'd0, bus.mem_req}, 32'd1);
            check({tag, "_mwe"}, {31'd0, bus.mem_we}, 32'd1);
            check({tag, "_maddr"}, {15'd0, bus.mem_addr}, a & 32'h0001FFFC);
            check({tag, "_strb"}, {28'd0, bus.mem_wstrb}, {28'd0, exp_strb});
            check({tag, "_wdata"}, bus.mem_wdata, exp_wdata);
            check({tag, "_stall_c"}, {31'd0, bus.stall}, (k < lat) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        bus.we = 1'b0; bus.mem_ack = 1'b0;
        #1;
        check({tag, "_req_end"}, {31'd0, bus.mem_req}, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.re = 1'b0; bus.we = 1'b0; bus.funct3 = 3'b010; bus.addr = 32'd0;
        bus.wd = 32'd0; bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;

        // Reset: outputs quiet even with a request present.
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.re = 1'b1; bus.addr = 32'h100;
        #1;
        check("rst_stall", {31'd0, bus.stall}, 32'd0);
        check("rst_rd", bus.rd, 32'd0);
        check("rst_req", {31'd0, bus.mem_req}, 32'd0);
        check("rst_mwe", {31'd0, bus.mem_we}, 32'd0);
        check("rst_strb", {28'd0, bus.mem_wstrb}, 32'd0);
        bus.re = 1'b0;
        rst = 1'b0;

        // Miss with ack on the 3rd request cycle, then repeat hits.
        do_load("lw_miss", 3'b010, 32'h100, 1'b0, 3, 32'hDEADBEEF, 32'hDEADBEEF);
        do_load("lw_hit", 3'b010, 32'h100, 1'b1, 0, 32'd0, 32'hDEADBEEF);
`ifdef DCACHE_STATS_EN
        check("stat_hit1", hit_count, 32'd1);
        check("stat_miss1", miss_count, 32'd1);
`endif

        // Same-index conflict: 0x200 evicts 0x100, which then misses again.
        do_load("conf_200", 3'b010, 32'h200, 1'b0, 1, 32'h0A0B0C0D, 32'h0A0B0C0D);
        do_load("conf_100", 3'b010, 32'h100, 1'b0, 2, 32'h80112233, 32'h80112233);

        // Extraction on line 0x100 = 0x80112233.
        do_load("lb_103", 3'b000, 32'h103, 1'b1, 0, 32'd0, 32'hFFFFFF80);
        do_load("lbu_103", 3'b100, 32'h103, 1'b1, 0, 32'd0, 32'h00000080);
        do_load("lh_102", 3'b001, 32'h102, 1'b1, 0, 32'd0, 32'hFFFF8011);
        do_load("lhu_100", 3'b101, 32'h100, 1'b1, 0, 32'd0, 32'h00002233);

        // Store hits merge into the line.
        do_store("sw_100", 3'b010, 32'h100, 32'h11223344, 1, 4'b1111, 32'h11223344);
        do_load("lw_sw", 3'b010, 32'h100, 1'b1, 0, 32'd0, 32'h11223344);
        do_store("sb_101", 3'b000, 32'h101, 32'h000000AA, 2, 4'b0010, 32'h0000AA00);
        do_load("lw_sb", 3'b010, 32'h100, 1'b1, 0, 32'd0, 32'h1122AA44);

        // Store miss: write-through, no allocation.
        do_store("sw_300", 3'b010, 32'h300, 32'h12345678, 1, 4'b1111, 32'h12345678);
        do_load("lw_300", 3'b010, 32'h300, 1'b0, 1, 32'hCAFEF00D, 32'hCAFEF00D);
        do_store("sh_302", 3'b001, 32'h302, 32'h0000BEEF, 1, 4'b1100, 32'hBEEF0000);
        do_load("lw_sh", 3'b010, 32'h300, 1'b1, 0, 32'd0, 32'hBEEFF00D);

        // Reset in the middle of a read miss.
        @(negedge clk);
        bus.re = 1'b1; bus.we = 1'b0; bus.funct3 = 3'b010; bus.addr = 32'h100;
        #1;
        check("rm_stall", {31'd0, bus.stall}, 32'd1);
        @(negedge clk);
        #1;
        check("rm_req", {31'd0, bus.mem_req}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rm_req_rst", {31'd0, bus.mem_req}, 32'd0);
        check("rm_stall_rst", {31'd0, bus.stall}, 32'd0);
        rst = 1'b0; bus.re = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
        #1;
        check("late_ack_req", {31'd0, bus.mem_req}, 32'd0);
        check("late_ack_stall", {31'd0, bus.stall}, 32'd0);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        #1;
        check("late_ack_idle", {31'd0, bus.mem_req}, 32'd0);
        do_load("post_rst", 3'b010, 32'h100, 1'b0, 2, 32'h55AA55AA, 32'h55AA55AA);
`ifdef DCACHE_STATS_EN
        check("stat_hit2", hit_count, 32'd0);
        check("stat_miss2", miss_count, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
